// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module   : alu_reservation_station
// Purpose  : Reservation station for non-memory ops. It sits after the ROB
//            issue port, buffers issued ops, snoops the ROB commit broadcast
//            to resolve pending operands, and dispatches one ready op per
//            cycle to the ALU. It back-pressures the ROB when full. The ROB
//            exception line flushes every slot.
// Ports    : clk, rst (sync, active-low)
//            ROB issue  : is_empty/is_sl/op/pc/v1/v2/q1/q2/imm _from_rob
//            ROB commit : is_finish/commit_pc/commit_data _from_rob
//            ROB flush  : is_exception_from_rob
//            To ROB     : is_stall_to_rob (registered "station full")
//            To ALU     : is_finish_to_alu (1-cycle pulse), op/pc/v1/v2/imm
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OpcodeLength
`define OpcodeLength 5
`endif
`ifndef PcLength
`define PcLength 31
`endif
`ifndef DataLength
`define DataLength 31
`endif

module alu_reservation_station #(
    parameter int Entries   = 8,
    parameter int IdxLength = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     is_exception_from_rob,
    input  logic                     is_empty_from_rob,
    input  logic                     is_sl_from_rob,
    input  logic [`OpcodeLength:0]   op_from_rob,
    input  logic [`PcLength:0]       pc_from_rob,
    input  logic [`DataLength:0]     v1_from_rob,
    input  logic [`DataLength:0]     v2_from_rob,
    input  logic [`PcLength:0]       q1_from_rob,
    input  logic [`PcLength:0]       q2_from_rob,
    input  logic [`DataLength:0]     imm_from_rob,
    input  logic                     is_finish_from_rob,
    input  logic [`PcLength:0]       commit_pc_from_rob,
    input  logic [`DataLength:0]     commit_data_from_rob,
    output logic                     is_stall_to_rob,
    output logic                     is_finish_to_alu,
    output logic [`OpcodeLength:0]   op_to_alu,
    output logic [`PcLength:0]       pc_to_alu,
    output logic [`DataLength:0]     v1_to_alu,
    output logic [`DataLength:0]     v2_to_alu,
    output logic [`DataLength:0]     imm_to_alu
);

    localparam int CW = IdxLength + 2;   // counts 0..Entries inclusive
    localparam logic [CW-1:0] c_ENTRIES = CW'(Entries);

    logic [Entries-1:0]     r_busy;
    logic [`OpcodeLength:0] r_op  [Entries];
    logic [`PcLength:0]     r_pc  [Entries];
    logic [`DataLength:0]   r_v1  [Entries];
    logic [`DataLength:0]   r_v2  [Entries];
    logic [`PcLength:0]     r_q1  [Entries];
    logic [`PcLength:0]     r_q2  [Entries];
    logic [`DataLength:0]   r_imm [Entries];
    logic [CW-1:0]          r_count;

    logic                   w_free_found;
    logic [IdxLength:0]     w_free_idx;
    logic                   w_rdy_found;
    logic [IdxLength:0]     w_rdy_idx;
    logic                   w_accept;
    logic                   w_fwd1;
    logic                   w_fwd2;
    logic [CW-1:0]          w_count_next;

    // Lowest-index free and ready slots, both from start-of-cycle state.
    // Scanning high-to-low lets the last hit (lowest index) win.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = '0;
        for (int i = Entries - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = (IdxLength + 1)'(i);
            end
            if (r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0)) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = (IdxLength + 1)'(i);
            end
        end
    end

    assign w_accept = !is_empty_from_rob && !is_sl_from_rob && w_free_found;

    // Forward a commit that lands on the same edge as the issue so it is
    // not missed by the slot being written.
    assign w_fwd1 = is_finish_from_rob && (q1_from_rob != '0)
                    && (q1_from_rob == commit_pc_from_rob);
    assign w_fwd2 = is_finish_from_rob && (q2_from_rob != '0)
                    && (q2_from_rob == commit_pc_from_rob);

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_rdy_found) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_accept && w_rdy_found) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || is_exception_from_rob) begin
            r_busy           <= '0;
            r_count          <= '0;
            is_stall_to_rob  <= 1'b0;
            is_finish_to_alu <= 1'b0;
            op_to_alu        <= '0;
            pc_to_alu        <= '0;
            v1_to_alu        <= '0;
            v2_to_alu        <= '0;
            imm_to_alu       <= '0;
            for (int i = 0; i < Entries; i++) begin
                r_op[i]  <= '0;
                r_pc[i]  <= '0;
                r_v1[i]  <= '0;
                r_v2[i]  <= '0;
                r_q1[i]  <= '0;
                r_q2[i]  <= '0;
                r_imm[i] <= '0;
            end
        end else begin
            // Snoop the commit broadcast into every waiting operand.
            for (int i = 0; i < Entries; i++) begin
                if (r_busy[i] && is_finish_from_rob) begin
                    if ((r_q1[i] != '0) && (r_q1[i] == commit_pc_from_rob)) begin
                        r_v1[i] <= commit_data_from_rob;
                        r_q1[i] <= '0;
                    end
                    if ((r_q2[i] != '0) && (r_q2[i] == commit_pc_from_rob)) begin
                        r_v2[i] <= commit_data_from_rob;
                        r_q2[i] <= '0;
                    end
                end
            end

            // Dispatch; a ready slot never has pending tags, so it never
            // collides with the snoop writes above.
            if (w_rdy_found) begin
                is_finish_to_alu  <= 1'b1;
                op_to_alu         <= r_op[w_rdy_idx];
                pc_to_alu         <= r_pc[w_rdy_idx];
                v1_to_alu         <= r_v1[w_rdy_idx];
                v2_to_alu         <= r_v2[w_rdy_idx];
                imm_to_alu        <= r_imm[w_rdy_idx];
                r_busy[w_rdy_idx] <= 1'b0;
            end else begin
                is_finish_to_alu  <= 1'b0;
            end

            // Issue into a slot that was free at the start of the cycle;
            // it is therefore never the slot being dispatched.
            if (w_accept) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= op_from_rob;
                r_pc[w_free_idx]   <= pc_from_rob;
                r_imm[w_free_idx]  <= imm_from_rob;
                r_v1[w_free_idx]   <= w_fwd1 ? commit_data_from_rob : v1_from_rob;
                r_q1[w_free_idx]   <= w_fwd1 ? '0 : q1_from_rob;
                r_v2[w_free_idx]   <= w_fwd2 ? commit_data_from_rob : v2_from_rob;
                r_q2[w_free_idx]   <= w_fwd2 ? '0 : q2_from_rob;
            end

            r_count         <= w_count_next;
            is_stall_to_rob <= (w_count_next == c_ENTRIES);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
// ============================================================================
// Module   : tb_alu_reservation_station
// Purpose  : Directed self-checking bench for alu_reservation_station.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_reservation_station;

    logic        clk;
    logic        rst;
    logic        is_exception_from_rob;
    logic        is_empty_from_rob;
    logic        is_sl_from_rob;
    logic [5:0]  op_from_rob;
    logic [31:0] pc_from_rob;
    logic [31:0] v1_from_rob;
    logic [31:0] v2_from_rob;
    logic [31:0] q1_from_rob;
    logic [31:0] q2_from_rob;
    logic [31:0] imm_from_rob;
    logic        is_finish_from_rob;
    logic [31:0] commit_pc_from_rob;
    logic [31:0] commit_data_from_rob;
    logic        is_stall_to_rob;
    logic        is_finish_to_alu;
    logic [5:0]  op_to_alu;
    logic [31:0] pc_to_alu;
    logic [31:0] v1_to_alu;
    logic [31:0] v2_to_alu;
    logic [31:0] imm_to_alu;

    int checks = 0;
    int errors = 0;

    alu_reservation_station #(.Entries(8), .IdxLength(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .is_exception_from_rob(is_exception_from_rob),
        .is_empty_from_rob    (is_empty_from_rob),
        .is_sl_from_rob       (is_sl_from_rob),
        .op_from_rob          (op_from_rob),
        .pc_from_rob          (pc_from_rob),
        .v1_from_rob          (v1_from_rob),
        .v2_from_rob          (v2_from_rob),
        .q1_from_rob          (q1_from_rob),
        .q2_from_rob          (q2_from_rob),
        .imm_from_rob         (imm_from_rob),
        .is_finish_from_rob   (is_finish_from_rob),
        .commit_pc_from_rob   (commit_pc_from_rob),
        .commit_data_from_rob (commit_data_from_rob),
        .is_stall_to_rob      (is_stall_to_rob),
        .is_finish_to_alu     (is_finish_to_alu),
        .op_to_alu            (op_to_alu),
        .pc_to_alu            (pc_to_alu),
        .v1_to_alu            (v1_to_alu),
        .v2_to_alu            (v2_to_alu),
        .imm_to_alu           (imm_to_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [5:0] op,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] q1, input logic [31:0] q2,
                         input logic [31:0] imm);
        is_empty_from_rob = 1'b0;
        is_sl_from_rob    = 1'b0;
        pc_from_rob       = pc;
        op_from_rob       = op;
        v1_from_rob       = v1;
        v2_from_rob       = v2;
        q1_from_rob       = q1;
        q2_from_rob       = q2;
        imm_from_rob      = imm;
    endtask

    task automatic bcast(input logic [31:0] pc, input logic [31:0] data);
        is_finish_from_rob   = 1'b1;
        commit_pc_from_rob   = pc;
        commit_data_from_rob = data;
    endtask

    task automatic idle();
        is_empty_from_rob     = 1'b1;
        is_sl_from_rob        = 1'b0;
        is_finish_from_rob    = 1'b0;
        is_exception_from_rob = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        op_from_rob = '0; pc_from_rob = '0; v1_from_rob = '0; v2_from_rob = '0;
        q1_from_rob = '0; q2_from_rob = '0; imm_from_rob = '0;
        commit_pc_from_rob = '0; commit_data_from_rob = '0;

        // Reset held while a ready op is offered: nothing gets in.
        issue(32'h20, 6'h01, 32'd1, 32'd2, 32'h0, 32'h0, 32'd3);
        tick(); tick();
        chk("rst_finish", is_finish_to_alu, 1'b0);
        chk("rst_stall",  is_stall_to_rob,  1'b0);
        chk("rst_pc",     pc_to_alu,        32'h0);
        chk("rst_v1",     v1_to_alu,        32'h0);
        idle();
        rst = 1'b1;
        tick();
        chk("rst_nodisp", is_finish_to_alu, 1'b0);

        // Ready issue: dispatch after the following edge.
        issue(32'h04, 6'h01, 32'd5, 32'd7, 32'h0, 32'h0, 32'd3);
        tick();
        idle();
        chk("rdy_early", is_finish_to_alu, 1'b0);
        tick();
        chk("rdy_fin",  is_finish_to_alu, 1'b1);
        chk("rdy_pc",   pc_to_alu,  32'h04);
        chk("rdy_op",   op_to_alu,  6'h01);
        chk("rdy_v1",   v1_to_alu,  32'd5);
        chk("rdy_v2",   v2_to_alu,  32'd7);
        chk("rdy_imm",  imm_to_alu, 32'd3);
        tick();
        chk("rdy_pulse", is_finish_to_alu, 1'b0);
        chk("rdy_hold",  pc_to_alu, 32'h04);

        // Snoop wake.
        issue(32'h08, 6'h02, 32'd0, 32'd2, 32'h04, 32'h0, 32'd0);
        tick();
        idle();
        tick();
        chk("snp_wait1", is_finish_to_alu, 1'b0);
        tick();
        chk("snp_wait2", is_finish_to_alu, 1'b0);
        bcast(32'h04, 32'h55);
        tick();
        idle();
        chk("snp_bcedge", is_finish_to_alu, 1'b0);
        tick();
        chk("snp_fin", is_finish_to_alu, 1'b1);
        chk("snp_pc",  pc_to_alu, 32'h08);
        chk("snp_v1",  v1_to_alu, 32'h55);
        chk("snp_v2",  v2_to_alu, 32'd2);

        // Forward on the issue edge.
        issue(32'h0C, 6'h03, 32'd1, 32'd0, 32'h0, 32'h08, 32'd0);
        bcast(32'h08, 32'h99);
        tick();
        idle();
        tick();
        chk("fwd_fin", is_finish_to_alu, 1'b1);
        chk("fwd_pc",  pc_to_alu, 32'h0C);
        chk("fwd_v2",  v2_to_alu, 32'h99);
        tick();

        // Fill to full with ops that wait on tag 0x100.
        for (int k = 0; k < 8; k++) begin
            issue(32'h10 + 32'(4 * k), 6'h04, 32'd0, 32'(k), 32'h100, 32'h0, 32'd0);
            tick();
            if (k == 6) chk("full_stall7", is_stall_to_rob, 1'b0);
            if (k == 7) chk("full_stall8", is_stall_to_rob, 1'b1);
        end
        issue(32'h40, 6'h04, 32'd9, 32'd9, 32'h0, 32'h0, 32'd0);
        tick();
        idle();
        chk("full_drop_stall", is_stall_to_rob, 1'b1);
        chk("full_drop_fin",   is_finish_to_alu, 1'b0);
        tick();
        chk("full_drop_nodisp", is_finish_to_alu, 1'b0);
        bcast(32'h100, 32'd1);
        tick();
        idle();
        chk("full_bcedge", is_finish_to_alu, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_fin", is_finish_to_alu, 1'b1);
            chk("drain_pc",  pc_to_alu, 32'h10 + 32'(4 * k));
            chk("drain_v2",  v2_to_alu, 32'(k));
            chk("drain_v1",  v1_to_alu, 32'd1);
            if (k == 0) chk("drain_unstall", is_stall_to_rob, 1'b0);
        end
        tick();
        chk("drain_done", is_finish_to_alu, 1'b0);

        // Load/store issues are ignored.
        issue(32'h50, 6'h05, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0);
        is_sl_from_rob = 1'b1;
        tick();
        idle();
        tick();
        chk("sl_ignored", is_finish_to_alu, 1'b0);

        // Two ready slots (0 and 2): lowest first.
        issue(32'h60, 6'h06, 32'd0, 32'd0, 32'h200, 32'h0, 32'd0);
        tick();
        issue(32'h64, 6'h06, 32'd0, 32'd0, 32'h300, 32'h0, 32'd0);
        tick();
        issue(32'h68, 6'h06, 32'd0, 32'd0, 32'h200, 32'h0, 32'd0);
        tick();
        idle();
        bcast(32'h200, 32'd7);
        tick();
        idle();
        tick();
        chk("ord_fin0", is_finish_to_alu, 1'b1);
        chk("ord_pc0",  pc_to_alu, 32'h60);
        chk("ord_v10",  v1_to_alu, 32'd7);
        tick();
        chk("ord_fin2", is_finish_to_alu, 1'b1);
        chk("ord_pc2",  pc_to_alu, 32'h68);
        tick();
        chk("ord_done", is_finish_to_alu, 1'b0);

        // Flush with three slots occupied, plus a same-cycle issue/broadcast.
        issue(32'h70, 6'h07, 32'd0, 32'd0, 32'h400, 32'h0, 32'd0);
        tick();
        issue(32'h74, 6'h07, 32'd0, 32'd0, 32'h400, 32'h0, 32'd0);
        tick();
        issue(32'h78, 6'h07, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0);
        bcast(32'h300, 32'd3);
        is_exception_from_rob = 1'b1;
        tick();
        idle();
        chk("fl_fin",   is_finish_to_alu, 1'b0);
        chk("fl_stall", is_stall_to_rob,  1'b0);
        chk("fl_pc",    pc_to_alu, 32'h0);
        bcast(32'h400, 32'd4);
        tick();
        bcast(32'h300, 32'd3);
        tick();
        idle();
        chk("fl_nodisp1", is_finish_to_alu, 1'b0);
        tick();
        chk("fl_nodisp2", is_finish_to_alu, 1'b0);
        tick();
        chk("fl_nodisp3", is_finish_to_alu, 1'b0);

        // Occupancy restarted from 0: full again only after 8 more.
        for (int k = 0; k < 8; k++) begin
            issue(32'h80 + 32'(4 * k), 6'h08, 32'd0, 32'd0, 32'h500, 32'h0, 32'd0);
            tick();
            if (k == 6) chk("fl_occ7", is_stall_to_rob, 1'b0);
            if (k == 7) chk("fl_occ8", is_stall_to_rob, 1'b1);
        end
        idle();
        rst = 1'b0;
        tick();
        chk("rst2_stall", is_stall_to_rob, 1'b0);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station for non-memory instructions, directly downstream of the reorder buffer's issue port.
- Buffers issued ops and snoops the ROB commit broadcast to resolve pending operands.
- Dispatches one ready op per cycle to the ALU and asserts back-pressure to the ROB when full.
- The reorder buffer's exception line flushes all entries.

Parameters:
- Entries, 8, number of station slots (power of two, 2..16)
- IdxLength, 2, slot index width minus 1 (log2(Entries)-1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- is_exception_from_rob  input  1  flush request
- is_empty_from_rob  input  1  1 = no issue this cycle
- is_sl_from_rob  input  1  1 = issued op is load/store (not for this block)
- op_from_rob  input  `OpcodeLength+1  issued opcode
- pc_from_rob  input  `PcLength+1  issued pc; also the op's tag
- v1_from_rob, v2_from_rob  input  `DataLength+1 each  operand values
- q1_from_rob, q2_from_rob  input  `PcLength+1 each  producer tag; 0 = value valid
- imm_from_rob  input  `DataLength+1  immediate
- is_finish_from_rob  input  1  commit broadcast valid
- commit_pc_from_rob  input  `PcLength+1  committing tag
- commit_data_from_rob  input  `DataLength+1  committing value
- is_stall_to_rob  output  1  station full
- is_finish_to_alu  output  1  dispatch valid, one-cycle pulse
- op_to_alu  output  `OpcodeLength+1  dispatched opcode
- pc_to_alu  output  `PcLength+1  dispatched pc
- v1_to_alu, v2_to_alu, imm_to_alu  output  `DataLength+1 each  dispatched operands

Behaviour:
- Reset (rst==0 at a clk edge):
  - All slots invalid.
  - All outputs 0, including is_stall_to_rob=0.
  - Reset has priority over every other input.
- Flush (rst==1, is_exception_from_rob==1):
  - Same effect as reset, next edge.
  - Issue, broadcast and dispatch in that cycle are discarded.
- Slot contents: busy, op, pc, v1, v2, q1, q2, imm.
- Issue accept:
  - Condition: is_empty_from_rob==0 && is_sl_from_rob==0 && a free slot exists at the start of the cycle.
  - Writes the lowest-index free slot.
  - Issue while full is dropped; the ROB must honour is_stall_to_rob.
- Issue forwarding:
  - If is_finish_from_rob==1 and an incoming q1/q2 (nonzero) equals commit_pc_from_rob, the slot stores commit_data as the value with q=0.
  - Broadcast is never lost on the issue edge.
- Snoop: every busy slot with nonzero qX == commit_pc_from_rob takes vX=commit_data and qX=0 on the edge.
- Ready rule: busy && q1==0 && q2==0, evaluated on register state at the start of the cycle.
  - Operands woken this edge dispatch no earlier than the next edge (one-cycle wake-to-dispatch latency).
- Dispatch:
  - Lowest-index ready slot is registered onto the *_to_alu outputs, is_finish_to_alu=1, and the slot is freed the same edge.
  - If no slot is ready: is_finish_to_alu=0; data outputs hold their last value.
- Latency: issue with both q=0 at edge N → slot busy after N → is_finish_to_alu high after edge N+1.
- Simultaneous dispatch + issue in one cycle:
  - Both happen.
  - The freed slot is not reusable until the next cycle (free check uses start-of-cycle state).
- is_stall_to_rob:
  - Registered; equals 1 when occupancy after the edge == Entries.
  - Occupancy counter range 0..Entries with no wrap.
  - Counter: +1 on accept, -1 on dispatch, net 0 when both.
- Tag 0 is reserved as "ready"; the pc of an issued op is never 0 in a tag field.

Test Plan:
- Reset/flush: hold rst=0 for 2 cycles while issuing → all outputs 0, is_stall_to_rob=0. Then fill 3 slots and pulse is_exception_from_rob → no dispatch afterwards, occupancy 0.
- Ready issue: op=ADD, pc=0x04, v1=5, v2=7, q1=q2=0 at edge 1 → is_finish_to_alu=1 after edge 2 with pc_to_alu=0x04, v1_to_alu=5, v2_to_alu=7; 0 after edge 3.
- Snoop wake: issue pc=0x08, q1=0x04. Two cycles later broadcast commit_pc=0x04, data=0x55 → dispatch one edge after the broadcast with v1_to_alu=0x55. Dispatch occurs neither before the broadcast nor on the broadcast edge.
- Issue-cycle forward: issue pc=0x0C, q2=0x08 in the same cycle as broadcast 0x08/0x99 → dispatch next edge with v2_to_alu=0x99.
- Full/stall: Entries=8, issue 8 ops with q1=0x100 (never committed) → is_stall_to_rob=1 after the 8th. 9th issue is dropped. Broadcast 0x100/1 → one dispatch per cycle for 8 cycles, lowest slot first. is_stall_to_rob=0 after the first dispatch.
- Filtering/order: issue with is_sl_from_rob=1 → ignored. Two ready ops in slots 0 and 2 → slot 0 dispatches first, slot 2 on the next cycle.
